fetch_sequencer: RTL
====================

# fetch_sequencer

Run controller and program-counter stage that sits directly upstream of the instruction memory and control decoder in the 9-bit single-cycle core. Owns the start/done handshake with the testbench, holds the core idle until a program is launched, and produces the PC each cycle: sequential, branch-redirected, or frozen on halt. It supplies the `run_en` qualifier that the core uses to gate register-file and data-memory writes.

## Interface
Parameters:
- `PC_WIDTH`, 10, PC/instruction-address width; instruction memory depth is 2^PC_WIDTH.
- `START_PC`, 0, PC loaded on reset and on every program launch.
- `CNT_WIDTH`, 16, width of the saturating cycle counter.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: launch request from the testbench, level-sensitive.
- `halt` in 1: decoder's done decode of the current instruction, combinational.
- `branch_taken` in 1: `branch_en & zero` for the current instruction.
- `branch_offset` in 8: signed immediate of the current instruction.
- `pc` out PC_WIDTH: address of the instruction executing this cycle.
- `run_en` out 1: core may commit state this cycle.
- `done` out 1: program finished, registered.
- `pc_wrap` out 1: sticky error; PC ran off the end of instruction memory.
- `cycle_count` out CNT_WIDTH: RUN cycles executed in the current program.

## Operation
- States: IDLE, ARMED, RUN, HALTED.
- Reset, in any state and mid-run: IDLE, `pc`=START_PC, `done`=0, `run_en`=0, `pc_wrap`=0, `cycle_count`=0.
- IDLE: `start`=1 goes to ARMED.
- ARMED: hold while `start`=1. On `start`=0, go to RUN; `pc` is START_PC and `cycle_count` is 0.
- RUN: `run_en`=1. Next PC is selected in this priority:
  - `halt`=1: go to HALTED, `pc` holds.
  - `branch_taken`=1: pc+1+sext(branch_offset), modulo 2^PC_WIDTH.
  - otherwise pc+1.
- `start` is ignored in RUN.
- Wrap detection, only when `halt`=0:
  - Sequential increment from 2^PC_WIDTH-1 sets `pc_wrap` and goes to HALTED.
  - Branch targets wrap silently and do not set `pc_wrap`.
- `cycle_count` increments on every RUN cycle, including the halting cycle, and saturates at all-ones.
- HALTED: `done`=1, `run_en`=0, `pc` frozen.
  - `start`=1 goes to ARMED: clears `done`, `pc_wrap` and `cycle_count`, and loads `pc`=START_PC.

## Timing
- `pc`, `done`, `pc_wrap`, `cycle_count` and the state are registered. `run_en` is decoded from the state register only, so it has no combinational path from any input.
- `pc` changes one cycle after the branch/halt inputs are sampled; redirect penalty is 0.
- `done` rises on the edge that samples `halt`=1 in RUN.
- First RUN cycle follows the edge that samples `start`=0 in ARMED. Start-to-first-fetch latency is 1 cycle after `start` falls.
- `halt` and `branch_taken` in the same cycle: halt wins, no redirect.
- HALTED with `start`=1 held: stays in ARMED until `start` falls.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (IDLE/ARMED/RUN/HALTED).
  - `BR_OFF_W`=8.
  - default `START_PC`.
- One combinational sub-module, `pc_next_calc`:
  - computes pc+1 and the branch target;
  - flags sequential overflow;
  - performs the priority select.
- The FSM and registers stay in `fetch_sequencer`.

## Test plan
- Launch and count: reset, `start` high for 3 cycles then low, `halt` asserted when `pc`=5.
  - `pc` runs 0,1,2,3,4,5 then holds at 5.
  - `done`=1 one cycle later.
  - `cycle_count`=6; `run_en` high for exactly 6 cycles.
- Branches: `branch_taken` at pc=4 with offset 0xFD (−3) gives next pc=2. At pc=2 with offset 0x05 gives pc=8.
- Halt over branch: `halt`=1 and `branch_taken`=1 with offset 0x10 at pc=7.
  - `pc` stays 7, `done`=1.
- Wrap: PC_WIDTH=4, no halt.
  - After pc=15, `pc_wrap`=1, `done`=1, `pc` holds 15.
  - A branch from pc=14 with offset 0x02 goes to pc=1 with no `pc_wrap`.
- Relaunch and reset mid-run:
  - From HALTED, pulse `start`: `done` clears on the edge that samples `start`=1, and `pc` returns to 0.
  - Assert `reset` low at an arbitrary point in RUN at pc=9: all outputs clear immediately, without waiting for a clock edge.
- Start ignored in RUN: toggle `start` during RUN.
  - PC sequence and `cycle_count` are unaffected.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its next-PC logic.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam int BR_OFF_W         = 8;
  localparam int START_PC_DEFAULT = 0;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the RUN state: halt hold, branch redirect or sequential step.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [BR_OFF_W-1:0] branch_offset,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                seq_wrap
);

  logic [PC_WIDTH:0]   seq_sum;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] br_target;

  assign seq_sum   = {1'b0, pc} + {{PC_WIDTH{1'b0}}, 1'b1};
  // Sign-extend (or truncate) the offset; the target is taken modulo 2^PC_WIDTH.
  assign off_ext   = PC_WIDTH'($signed(branch_offset));
  assign br_target = pc + PC_WIDTH'(1) + off_ext;

  always_comb begin
    pc_next  = seq_sum[PC_WIDTH-1:0];
    seq_wrap = 1'b0;
    if (halt) begin
      pc_next = pc;
    end else if (branch_taken) begin
      pc_next = br_target;
    end else if (seq_sum[PC_WIDTH]) begin
      seq_wrap = 1'b1;
      pc_next  = pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Run controller and PC register for the 9-bit core: start/done handshake,
// PC sequencing and the run_en commit qualifier.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARMED  | start seen, waiting for start to drop; pc at START_PC
// RUN    | executing, one instruction per cycle, run_en high
// HALTED | program done (halt or pc wrap), pc frozen, done high
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH  = 10,
  parameter int START_PC  = START_PC_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 branch_taken,
  input  logic [BR_OFF_W-1:0]  branch_offset,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 run_en,
  output logic                 done,
  output logic                 pc_wrap,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [PC_WIDTH-1:0] PC_START = PC_WIDTH'(START_PC);

  fetch_state_t         state, state_next;
  logic [PC_WIDTH-1:0]  pc_next, pc_d;
  logic                 seq_wrap;
  logic                 done_d, wrap_d;
  logic [CNT_WIDTH-1:0] cnt_d;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next_calc (
    .pc            (pc),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_next       (pc_next),
    .seq_wrap      (seq_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= PC_START;
      done        <= 1'b0;
      pc_wrap     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_d;
      done        <= done_d;
      pc_wrap     <= wrap_d;
      cycle_count <= cnt_d;
    end
  end

  always_comb begin
    state_next = state;
    pc_d       = pc;
    done_d     = done;
    wrap_d     = pc_wrap;
    cnt_d      = cycle_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
          pc_d       = PC_START;
          cnt_d      = '0;
        end
      end
      ARMED: begin
        if (!start) state_next = RUN;
      end
      RUN: begin
        pc_d = pc_next;
        if (cycle_count != '1) cnt_d = cycle_count + CNT_WIDTH'(1);
        if (halt || seq_wrap) begin
          state_next = HALTED;
          done_d     = 1'b1;
        end
        if (seq_wrap) wrap_d = 1'b1;
      end
      HALTED: begin
        if (start) begin
          state_next = ARMED;
          done_d     = 1'b0;
          wrap_d     = 1'b0;
          cnt_d      = '0;
          pc_d       = PC_START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register only, so no input-to-output path.
  assign run_en = (state == RUN);

endmodule
